// File: rtl/fulladd_reg.sv
// fulladd_reg: registered WIDTH-bit ripple-carry adder with carry-in/out.
// The adder is a chain of single-bit full-adder cells. Sum and flags are
// captured into output flops one clock after a valid input, so there is no
// combinational path from any input to any output.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   a, b      in   WIDTH-bit operands (unsigned; two's complement for ovf)
//   c_in      in   carry into bit 0
//   in_valid  in   qualifies a/b/c_in for capture this cycle
//   sum       out  registered low WIDTH bits of a + b + c_in
//   c_out     out  registered carry out of bit WIDTH-1
//   ovf       out  registered signed overflow (carry into MSB ^ carry out)
//   zero      out  registered sum == 0 flag
//   out_valid out  registered copy of in_valid

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module fulladd_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;
  logic             zero_d;

  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_valid_q;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry[i]),
      .s_o (sum_d[i]),
      .c_o (carry[i+1])
    );
  end

  // Signed overflow: the carry into the sign bit disagrees with the carry out.
  assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
  assign zero_d = (sum_d == '0);

  // Flags only load on a valid input, so undefined operands while idle
  // never reach the output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        c_out_q <= carry[WIDTH];
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fulladd_reg.sv
module tb_fulladd_reg;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         c_in, in_valid;
  logic [W-1:0] sum;
  logic         c_out, ovf, zero, out_valid;

  fulladd_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Packed view {out_valid, zero, ovf, c_out, sum}
  typedef logic [W+3:0] obs_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         c, o, z;
  } vec_t;

  int n_pass = 0, n_total = 0;

  function automatic obs_t observed();
    return {out_valid, zero, ovf, c_out, sum};
  endfunction

  // Reference model from plain integer arithmetic.
  function automatic obs_t model(input int ai, input int bi, input int ci, input bit v);
    int u, sa, sb, ss;
    logic [W-1:0] s;
    logic co, ov, z;
    u  = ai + bi + ci;
    s  = u[W-1:0];
    co = (u >= (1 << W));
    sa = (ai >= (1 << (W-1))) ? ai - (1 << W) : ai;
    sb = (bi >= (1 << (W-1))) ? bi - (1 << W) : bi;
    ss = sa + sb + ci;
    ov = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    z  = (u % (1 << W)) == 0;
    return {v, z, ov, co, s};
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got {v,z,o,c,sum}=%b required %b", nm, act, exp);
    else
      n_pass++;
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic drive(input logic rn, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic v);
    @(negedge clk);
    rst_n = rn; a = av; b = bv; c_in = cv; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[7];
  obs_t last;

  initial begin
    rst_n = 1'b0; a = '0; b = '0; c_in = 1'b0; in_valid = 1'b0;

    tbl[0] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{4'h5, 4'h2, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};

    // Reset wins over in_valid, for two cycles.
    drive(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
    chk("reset_cyc1", observed(), '0);
    drive(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
    chk("reset_cyc2", observed(), '0);

    // Directed table, back-to-back.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
      chk($sformatf("table%0d", i), observed(),
          {1'b1, tbl[i].z, tbl[i].o, tbl[i].c, tbl[i].s});
    end

    // Hold: 5 random back-to-back, then a 3-cycle gap with junk operands.
    for (int i = 0; i < 5; i++) begin
      int ra, rb, rc;
      ra = $urandom_range(15); rb = $urandom_range(15); rc = $urandom_range(1);
      drive(1'b1, ra[W-1:0], rb[W-1:0], rc[0], 1'b1);
      last = model(ra, rb, rc, 1'b1);
      chk($sformatf("b2b%0d", i), observed(), last);
    end
    last[W+3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      chk($sformatf("hold%0d", i), observed(), last);
    end

    // Reset arriving with a valid input discards that result.
    drive(1'b1, 4'h3, 4'h4, 1'b0, 1'b1);
    chk("pre_rst", observed(), model(3, 4, 0, 1'b1));
    drive(1'b0, 4'h1, 4'h1, 1'b0, 1'b1);
    chk("mid_rst", observed(), '0);
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("post_rst_idle", observed(), '0);

    // Exhaustive sweep of a, b, c_in.
    for (int i = 0; i < 512; i++) begin
      int ea, eb, ec;
      ea = i & 15; eb = (i >> 4) & 15; ec = (i >> 8) & 1;
      drive(1'b1, ea[W-1:0], eb[W-1:0], ec[0], 1'b1);
      chk($sformatf("exh_%0d_%0d_%0d", ea, eb, ec), observed(), model(ea, eb, ec, 1'b1));
    end

    // Random mix of valid/idle cycles against the model with held state.
    last = observed();
    for (int i = 0; i < 200; i++) begin
      int ra, rb, rc, rv;
      ra = $urandom_range(15); rb = $urandom_range(15);
      rc = $urandom_range(1);  rv = $urandom_range(1);
      drive(1'b1, ra[W-1:0], rb[W-1:0], rc[0], rv[0]);
      if (rv[0]) last = model(ra, rb, rc, 1'b1);
      else last[W+3] = 1'b0;
      chk($sformatf("rand%0d", i), observed(), last);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fulladd_reg.md
Name: fulladd_reg

Overview:
- Registered WIDTH-bit ripple-carry adder with carry-in and carry-out. Default width is 4 bits.
- Built from per-bit full-adder cells: sum_i = a_i ^ b_i ^ c_i, c_(i+1) = majority(a_i, b_i, c_i).
- Result and status flags are captured in output registers one clock after a valid input.
- Used as the arithmetic leaf inside datapath blocks that need a clocked add with carry chaining.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- a, input, WIDTH, operand A, unsigned (also interpreted as two's complement for ovf).
- b, input, WIDTH, operand B.
- c_in, input, 1, carry into bit 0.
- in_valid, input, 1, qualifies a, b and c_in for capture this cycle.
- sum, output, WIDTH, registered low WIDTH bits of a + b + c_in.
- c_out, output, 1, registered carry out of bit WIDTH-1.
- ovf, output, 1, registered signed overflow: carry into MSB XOR carry out of MSB.
- zero, output, 1, registered flag, 1 when sum == 0.
- out_valid, output, 1, registered copy of in_valid; marks sum/c_out/ovf/zero as updated.

Behaviour:
- Reset: on a rising edge with rst_n = 0, sum = 0, c_out = 0, ovf = 0, zero = 0 and out_valid = 0. Reset takes priority over in_valid.
- Reset mid-operation: a result pending capture in that cycle is discarded.
- Arithmetic: {c_out, sum} = a + b + c_in, computed as a (WIDTH+1)-bit exact result. There is no saturation; wrap-around is modulo 2^WIDTH with the carry reported on c_out.
- Capture, latency 1: on a rising edge with rst_n = 1 and in_valid = 1, sum, c_out, ovf and zero load from the combinational adder; out_valid becomes 1.
- Hold: on a rising edge with rst_n = 1 and in_valid = 0, sum, c_out, ovf and zero keep their previous values; out_valid becomes 0.
- Throughput: one operation per cycle. Back-to-back in_valid cycles produce back-to-back out_valid cycles.
- Handshake: there is no backpressure and no ready signal; a result is held only until the next valid input.
- Inputs: X/undefined inputs while in_valid = 0 must not disturb the outputs.
- Outputs: driven only from flops; no combinational path from inputs to outputs.
- Carry chain: c_in feeds bit 0 and each cell's carry feeds the next bit. c_out is the carry from cell WIDTH-1.
- Boundary, all ones plus carry: a = all ones, b = 0, c_in = 1 gives sum = 0, c_out = 1, zero = 1.
- Boundary, maximum: a = b = all ones, c_in = 1 gives sum = all ones, c_out = 1.
- Boundary, WIDTH = 1: reduces to a single registered full adder.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1, a = 0xF, b = 0xF, c_in = 1 -> sum = 0x0, c_out = 0, ovf = 0, zero = 0, out_valid = 0.
- Single add: a = 0x3, b = 0x4, c_in = 0, in_valid = 1 -> next edge sum = 0x7, c_out = 0, ovf = 0, zero = 0, out_valid = 1.
- Carry/wrap: a = 0xF, b = 0x0, c_in = 1 -> sum = 0x0, c_out = 1, zero = 1. Then a = 0xF, b = 0xF, c_in = 1 -> sum = 0xF, c_out = 1.
- Signed overflow: a = 0x7, b = 0x1, c_in = 0 -> sum = 0x8, c_out = 0, ovf = 1. Then a = 0x8, b = 0x8, c_in = 0 -> sum = 0x0, c_out = 1, ovf = 1, zero = 1.
- Hold and throughput: apply 5 back-to-back random vectors, then drop in_valid for 3 cycles -> each result matches a + b + c_in one cycle later; outputs hold the last result; out_valid = 0 during the gap.
- Exhaustive (WIDTH = 4): sweep all 512 combinations of a, b, c_in -> every {c_out, sum} equals the integer sum a + b + c_in, checked one cycle after input.
